// File: rtl/alu_mac_ctrl.sv
// Dot-product sequencer driving an external combinational ALU: per element FETCH -> MUL -> ACC.
// Optional saturating accumulate when ALU_MAC_SATURATE_EN is defined.
module alu_mac_ctrl #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [15:0]      alu_in1,
    output logic [15:0]      alu_in2,
    output logic [2:0]       alu_op,
    input  logic [15:0]      alu_out,
    input  logic             alu_z,
    output logic [15:0]      result,
    output logic             result_zero,
    output logic             busy,
    output logic             done,
    output logic             result_valid
);

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpMul = 3'd2;

    typedef enum logic [2:0] {StIdle, StFetch, StMul, StAcc, StDone} state_e;

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [15:0]      prod_q, prod_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [15:0]      result_q, result_d;
    logic             result_zero_q, result_zero_d;

    logic [LEN_W-1:0] cnt_inc;
    logic [15:0]      acc_next;
    logic             zero_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            acc_q         <= '0;
            prod_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cnt_q         <= '0;
            len_q         <= '0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            prod_q        <= prod_d;
            a_q           <= a_d;
            b_q           <= b_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            result_q      <= result_d;
            result_zero_q <= result_zero_d;
        end
    end

    // The ALU sum is only meaningful in ACC, where alu_in1 is the accumulator.
    always_comb begin
        cnt_inc = cnt_q + LEN_W'(1);
`ifdef ALU_MAC_SATURATE_EN
        if (alu_out < acc_q) begin
            acc_next  = 16'hFFFF;
            zero_next = 1'b0;
        end else begin
            acc_next  = alu_out;
            zero_next = alu_z;
        end
`else
        acc_next  = alu_out;
        zero_next = alu_z;
`endif
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        prod_d        = prod_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        result_d      = result_q;
        result_zero_d = result_zero_q;
        op_ready      = 1'b0;
        alu_in1       = 16'd0;
        alu_in2       = 16'd0;
        alu_op        = OpAdd;

        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    if (len != '0) begin
                        len_d   = len;
                        state_d = StFetch;
                    end else begin
                        result_d      = '0;
                        result_zero_d = 1'b1;
                        state_d       = StDone;
                    end
                end
            end
            StFetch: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = StMul;
                end
            end
            StMul: begin
                alu_in1 = a_q;
                alu_in2 = b_q;
                alu_op  = OpMul;
                prod_d  = alu_out;
                state_d = StAcc;
            end
            StAcc: begin
                alu_in1 = acc_q;
                alu_in2 = prod_q;
                acc_d   = acc_next;
                cnt_d   = cnt_inc;
                if (cnt_inc == len_q) begin
                    // Result is loaded on entry to DONE so it is visible alongside the pulse.
                    result_d      = acc_next;
                    result_zero_d = zero_next;
                    state_d       = StDone;
                end else begin
                    state_d = StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign result       = result_q;
    assign result_zero  = result_zero_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign result_valid = (state_q == StDone);

endmodule

// File: tb/tb_alu_mac_ctrl.sv
// Scoreboard bench for alu_mac_ctrl with a behavioural ALU; directed dot-product vectors.
module tb_alu_mac_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_op;
    logic        alu_z;
    logic [15:0] result;
    logic        result_zero, busy, done, result_valid;
    logic [31:0] alu_full;

    alu_mac_ctrl #(.LEN_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .alu_z        (alu_z),
        .result       (result),
        .result_zero  (result_zero),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid)
    );

    always #5 clock = ~clock;

    assign alu_full = (alu_op == 3'd2) ? ({16'd0, alu_in1} * {16'd0, alu_in2})
                                       : ({16'd0, alu_in1} + {16'd0, alu_in2});
    assign alu_out  = alu_full[15:0];
    assign alu_z    = (alu_out == 16'd0);

    typedef struct {
        logic [15:0] res;
        logic        rz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          hs = 0;
    logic [15:0] pa[8];
    logic [15:0] pb[8];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pre-edge values are seen here; inputs only change #1 after the edge.
    always @(posedge clock) begin
        cyc++;
        if (op_valid && op_ready && !reset) hs++;
    end

    exp_t e;
    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done with result %0d, expected none (cycle %0d)",
                         result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("result_zero", int'(result_zero), int'(e.rz));
                chk("done_cycle", cyc, e.cyc);
                chk("result_valid", int'(result_valid), 1);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clock);
        while (!op_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!op_ready) chk("op_ready_timeout", 0, 1);
    endtask

    task automatic feed(input int k, input int stall);
        wait_ready();
        for (int i = 0; i < stall; i++) begin
            chk("op_ready_wait", int'(op_ready), 1);
            @(negedge clock);
        end
        op_valid = 1'b1;
        op_a     = pa[k];
        op_b     = pb[k];
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        start    = 1'b0;
        op_a     = 16'hDEAD;
        op_b     = 16'hBEEF;
    endtask

    task automatic run(input int n, input int stall, input logic [15:0] res, input logic rz,
                       input bit extra_start);
        exp_t x;
        int   hs0;
        int   t;
        @(posedge clock);
        #1;
        start = 1'b1;
        len   = 8'(n);
        x.res = res;
        x.rz  = rz;
        x.cyc = cyc + 3 * n + 1 + stall * n;
        sb.push_back(x);
        hs0 = hs;
        @(posedge clock);
        #1;
        start = extra_start;
        len   = 8'd3;
        if (n == 0) begin
            @(negedge clock);
            chk("op_ready_len0", int'(op_ready), 0);
        end
        for (int k = 0; k < n; k++) feed(k, stall);
        start = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(posedge clock);
            t++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        chk("pairs_consumed", hs - hs0, n);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_op_ready"}, int'(op_ready), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_result_valid"}, int'(result_valid), 0);
        chk({tag, "_result"}, int'(result), 0);
        chk({tag, "_result_zero"}, int'(result_zero), 1);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("reset");

        pa[0] = 16'd1; pb[0] = 16'd2;
        pa[1] = 16'd3; pb[1] = 16'd4;
        pa[2] = 16'd5; pb[2] = 16'd6;
        run(3, 0, 16'd44, 1'b0, 1'b0);

        run(0, 0, 16'd0, 1'b1, 1'b0);

        pa[0] = 16'd2; pb[0] = 16'd3;
        pa[1] = 16'd4; pb[1] = 16'd5;
        run(2, 4, 16'd26, 1'b0, 1'b0);

        pa[0] = 16'd255; pb[0] = 16'd255;
        pa[1] = 16'd255; pb[1] = 16'd255;
`ifdef ALU_MAC_SATURATE_EN
        run(2, 0, 16'd65535, 1'b0, 1'b0);
`else
        run(2, 0, 16'd64514, 1'b0, 1'b0);
`endif

        // Product wraps to zero inside the ALU.
        pa[0] = 16'd256; pb[0] = 16'd256;
        run(1, 0, 16'd0, 1'b1, 1'b0);

        pa[0] = 16'd1; pb[0] = 16'd1;
        pa[1] = 16'd1; pb[1] = 16'd1;
        run(2, 0, 16'd2, 1'b0, 1'b1);
        chk("result_hold", int'(result), 2);

        // Abort a len=4 run in its second MUL state.
        @(posedge clock);
        #1;
        start = 1'b1;
        len   = 8'd4;
        @(posedge clock);
        #1;
        start = 1'b0;
        pa[0] = 16'd9; pb[0] = 16'd9;
        pa[1] = 16'd8; pb[1] = 16'd8;
        feed(0, 0);
        feed(1, 0);
        chk("mul_before_reset", int'(alu_op), 2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("midreset");
        repeat (15) @(posedge clock);

        pa[0] = 16'd7; pb[0] = 16'd7;
        run(1, 0, 16'd49, 1'b0, 1'b0);

        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mac_ctrl.md
ALU_MAC_CTRL -- requirements
Module: alu_mac_ctrl

Interface
REQ-001 Parameter LEN_W, default 8: width of the element-count input len.
REQ-002 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port start  input  1  one-cycle request to begin a dot product of len element pairs.
REQ-005 Port len  input  LEN_W  element-pair count, sampled only when start is accepted.
REQ-006 Port op_a, op_b  input  16 each  operand pair, unsigned.
REQ-007 Port op_valid  input  1  operand pair present; op_ready  output  1  controller accepts the pair.
REQ-008 Port alu_in1, alu_in2  output  16 each  ALU operands; alu_op  output  3  ALU opcode.
REQ-009 Port alu_out  input  16  combinational ALU result; alu_z  input  1  ALU zero flag (alu_out==0).
REQ-010 Port result  output  16  final accumulated value; result_zero  output  1  result equals 0.
REQ-011 Port busy  output  1  high outside IDLE; done  output  1  one-cycle completion pulse, coincident with result_valid.
REQ-012 Opcodes driven: 3'd0 ADD, 3'd2 MUL; no other value is ever driven.

Function
REQ-013 States: IDLE, FETCH, MUL, ACC, DONE; binary encoded, one registered state variable.
REQ-014 IDLE: start=1 with len!=0 -> clear acc and count, latch len, go FETCH; start=1 with len==0 -> go DONE with acc=0; otherwise stay.
REQ-015 FETCH: op_ready=1 (only state where it is high); op_valid=1 -> latch op_a/op_b, go MUL; op_valid=0 -> stay, indefinitely.
REQ-016 MUL: alu_in1=latched a, alu_in2=latched b, alu_op=MUL; register alu_out as product; go ACC.
REQ-017 ACC: alu_in1=acc, alu_in2=product, alu_op=ADD; acc <= ALU sum (subject to REQ-026); result_zero candidate <= alu_z; count <= count+1.
REQ-018 ACC: count+1==len -> go DONE; else go FETCH.
REQ-019 DONE: result=acc, result_valid=done=1 for exactly this cycle; go IDLE unconditionally.
REQ-020 result and result_zero are registered and hold their value until the next DONE or reset.
REQ-021 Per-element latency: 1 FETCH cycle (with op_valid high) + MUL + ACC = 3 cycles; len=N with no stalls -> done asserted 3N+1 cycles after the start cycle.
REQ-022 start while busy=1 is ignored; len changes while busy have no effect.
REQ-023 In IDLE and DONE: alu_in1=alu_in2=0, alu_op=ADD.
REQ-024 All arithmetic is 16-bit unsigned; product is the ALU's 16-bit output (upper bits discarded by the ALU); count is LEN_W bits and never wraps (terminates at len).

Reset
REQ-025 reset=1 at any clock edge, including mid-operation -> state IDLE, acc=0, product=0, count=0, result=0, result_zero=1, op_ready=0, busy=0, done=0, result_valid=0; an operand in flight is dropped.

Configuration
REQ-026 Macro ALU_MAC_SATURATE_EN: defined -> in ACC, if ALU sum < acc (unsigned carry-out), acc <= 16'hFFFF and result_zero candidate <= 0; undefined -> acc <= ALU sum, wrapping modulo 2^16.

Verification
REQ-027 len=3, pairs (1,2),(3,4),(5,6), op_valid always high -> result=44, result_zero=0, done 10 cycles after start.
REQ-028 len=0 -> done/result_valid pulse 1 cycle after start, result=0, result_zero=1, op_ready never high.
REQ-029 len=2, pairs (2,3),(4,5), op_valid low 4 cycles before each pair -> op_ready held high while waiting, result=26, pairs consumed exactly once.
REQ-030 len=2, pairs (255,255),(255,255) -> result=64514 without ALU_MAC_SATURATE_EN, 65535 with it.
REQ-031 len=4 started, reset asserted in the second MUL state, then start len=1 pair (7,7) -> first run produces no done, second gives result=49.
REQ-032 start pulsed again in FETCH of len=2 run with pairs (1,1),(1,1) -> second start ignored, single done, result=2.
